// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_stage_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_INC  = 4;

    typedef enum logic [1:0] {
        S_RESET,
        S_FETCH,
        S_HOLD
    } state_e;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between fetch stage and memory.
interface if_stage_if
    import if_stage_pkg::*;
#(
    parameter int ADDR_W = 64
);

    logic               IMem_Req;
    logic [ADDR_W-1:0]  IMem_Addr;
    logic               IMem_Ready;
    logic [INSTR_W-1:0] IMem_Data;

    modport master (
        output IMem_Req,
        output IMem_Addr,
        input  IMem_Ready,
        input  IMem_Data
    );

    modport slave (
        input  IMem_Req,
        input  IMem_Addr,
        output IMem_Ready,
        output IMem_Data
    );

endinterface

// File: rtl/ifid_pipe_reg.sv
// IF/ID pipeline register: flush beats write-enable, sync active-low reset.
module ifid_pipe_reg
    import if_stage_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  pc_i,
    input  logic [INSTR_W-1:0] instr_i,
    output logic [ADDR_W-1:0]  pc_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic               valid_o
);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;

    // A flush keeps the old PC and only kills instruction and valid.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (flush) begin
            instr_d = '0;
            valid_d = 1'b0;
        end else if (we) begin
            pc_d    = pc_i;
            instr_d = instr_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// Fetch stage: PC sequencing, memory handshake, stall hold buffer, redirects.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               CLK,
    input  logic               Reset_L,
    input  logic               PC_WriteEn,
    input  logic               IFID_WriteEn,
    input  logic               Branch_Taken,
    input  logic [ADDR_W-1:0]  Branch_Target,
    if_stage_if.master         imem,
    output logic [ADDR_W-1:0]  IFID_PC,
    output logic [INSTR_W-1:0] IFID_Instr,
    output logic               IFID_Valid
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  hold_pc_q, hold_pc_d;
    logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
    logic [ADDR_W-1:0]  tgt_q, tgt_d;
    logic               pend_q, pend_d;

    logic               stall;
    logic [ADDR_W-1:0]  br_tgt;
    logic [ADDR_W-1:0]  pc_inc;
    logic               ifid_we;
    logic               ifid_flush;
    logic [ADDR_W-1:0]  ifid_pc_d;
    logic [INSTR_W-1:0] ifid_instr_d;

    assign stall  = !PC_WriteEn || !IFID_WriteEn;
    assign br_tgt = Branch_Target & {{(ADDR_W-2){1'b1}}, 2'b00};
    assign pc_inc = pc_q + ADDR_W'(PC_INC);

    assign imem.IMem_Req  = (state_q == S_FETCH);
    assign imem.IMem_Addr = pc_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        tgt_d        = tgt_q;
        pend_d       = pend_q;
        ifid_we      = 1'b0;
        ifid_flush   = Branch_Taken;
        ifid_pc_d    = pc_q;
        ifid_instr_d = imem.IMem_Data;
        unique case (state_q)
            S_RESET: begin
                state_d = S_FETCH;
                pc_d    = RESET_PC;
            end
            S_FETCH: begin
                if (Branch_Taken) begin
                    // Without a response the address must stay put, so defer.
                    if (imem.IMem_Ready) begin
                        pc_d   = br_tgt;
                        pend_d = 1'b0;
                    end else begin
                        pend_d = 1'b1;
                        tgt_d  = br_tgt;
                    end
                end else if (imem.IMem_Ready) begin
                    if (pend_q) begin
                        pc_d       = tgt_q;
                        pend_d     = 1'b0;
                        ifid_flush = !stall;
                    end else if (stall) begin
                        hold_pc_d    = pc_q;
                        hold_instr_d = imem.IMem_Data;
                        state_d      = S_HOLD;
                    end else begin
                        ifid_we = 1'b1;
                        pc_d    = pc_inc;
                    end
                end else begin
                    ifid_flush = !stall;
                end
            end
            S_HOLD: begin
                if (Branch_Taken) begin
                    pc_d    = br_tgt;
                    state_d = S_FETCH;
                end else if (!stall) begin
                    ifid_we      = 1'b1;
                    ifid_pc_d    = hold_pc_q;
                    ifid_instr_d = hold_instr_q;
                    pc_d         = pc_inc;
                    state_d      = S_FETCH;
                end
            end
            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            state_q      <= S_RESET;
            pc_q         <= RESET_PC;
            hold_pc_q    <= '0;
            hold_instr_q <= '0;
            tgt_q        <= '0;
            pend_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
            tgt_q        <= tgt_d;
            pend_q       <= pend_d;
        end
    end

    ifid_pipe_reg #(
        .ADDR_W (ADDR_W)
    ) u_ifid (
        .clk     (CLK),
        .rst_n   (Reset_L),
        .we      (ifid_we),
        .flush   (ifid_flush),
        .pc_i    (ifid_pc_d),
        .instr_i (ifid_instr_d),
        .pc_o    (IFID_PC),
        .instr_o (IFID_Instr),
        .valid_o (IFID_Valid)
    );

endmodule

// File: tb/tb_if_stage.sv
// Directed scenarios plus random traffic against a transaction-level fetch model.
module tb_if_stage;

    localparam logic [63:0] RST_PC = 64'h0;

    logic        CLK = 1'b0;
    logic        Reset_L;
    logic        PC_WriteEn;
    logic        IFID_WriteEn;
    logic        Branch_Taken;
    logic [63:0] Branch_Target;
    logic [63:0] IFID_PC;
    logic [31:0] IFID_Instr;
    logic        IFID_Valid;

    int n_cmp = 0;
    int n_err = 0;

    if_stage_if #(.ADDR_W(64)) bus ();

    if_stage #(
        .ADDR_W   (64),
        .RESET_PC (RST_PC)
    ) dut (
        .CLK           (CLK),
        .Reset_L       (Reset_L),
        .PC_WriteEn    (PC_WriteEn),
        .IFID_WriteEn  (IFID_WriteEn),
        .Branch_Taken  (Branch_Taken),
        .Branch_Target (Branch_Target),
        .imem          (bus.master),
        .IFID_PC       (IFID_PC),
        .IFID_Instr    (IFID_Instr),
        .IFID_Valid    (IFID_Valid)
    );

    always #5 CLK = ~CLK;

    // Reference: 0 = just reset, 1 = fetching, 2 = parked instruction.
    int          m_mode = 0;
    logic [63:0] m_pc   = RST_PC;
    logic [63:0] m_hpc  = '0;
    logic [31:0] m_hins = '0;
    bit          m_pend = 0;
    logic [63:0] m_tgt  = '0;
    logic [63:0] m_ifpc = '0;
    logic [31:0] m_ifin = '0;
    bit          m_ifv  = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    task automatic bubble();
        m_ifin = '0;
        m_ifv  = 0;
    endtask

    task automatic model(input bit rst, input bit pcw, input bit ifw,
                         input bit br, input logic [63:0] tgt,
                         input bit rdy, input logic [31:0] data);
        bit          stall;
        logic [63:0] t;
        if (!rst) begin
            m_mode = 0; m_pc = RST_PC; m_pend = 0;
            m_ifpc = '0; m_ifin = '0; m_ifv = 0;
            return;
        end
        stall = !pcw || !ifw;
        t = {tgt[63:2], 2'b00};
        if (br) bubble();
        if (m_mode == 0) begin
            m_mode = 1;
            m_pc = RST_PC;
        end else if (m_mode == 2) begin
            if (br) begin
                m_pc = t; m_mode = 1;
            end else if (!stall) begin
                m_ifpc = m_hpc; m_ifin = m_hins; m_ifv = 1;
                m_pc = m_pc + 64'd4; m_mode = 1;
            end
        end else if (br) begin
            if (rdy) begin
                m_pc = t; m_pend = 0;
            end else begin
                m_pend = 1; m_tgt = t;
            end
        end else if (!rdy) begin
            if (!stall) bubble();
        end else if (m_pend) begin
            m_pc = m_tgt; m_pend = 0;
            if (!stall) bubble();
        end else if (stall) begin
            m_hpc = m_pc; m_hins = data; m_mode = 2;
        end else begin
            m_ifpc = m_pc; m_ifin = data; m_ifv = 1;
            m_pc = m_pc + 64'd4;
        end
    endtask

    task automatic step(input bit rst, input bit pcw, input bit ifw,
                        input bit br, input logic [63:0] tgt,
                        input bit rdy);
        Reset_L        = rst;
        PC_WriteEn     = pcw;
        IFID_WriteEn   = ifw;
        Branch_Taken   = br;
        Branch_Target  = tgt;
        bus.IMem_Ready = rdy;
        bus.IMem_Data  = $urandom;
        @(posedge CLK);
        model(rst, pcw, ifw, br, tgt, rdy, bus.IMem_Data);
        #1;
        chk("req",   {63'd0, bus.IMem_Req}, {63'd0, m_mode == 1});
        chk("addr",  bus.IMem_Addr, m_pc);
        chk("ifpc",  IFID_PC, m_ifpc);
        chk("ifins", {32'd0, IFID_Instr}, {32'd0, m_ifin});
        chk("ifv",   {63'd0, IFID_Valid}, {63'd0, m_ifv});
    endtask

    task automatic run(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1, 1, 1, 0, '0, rdy);
    endtask

    initial begin
        step(0, 1, 1, 0, '0, 1);
        step(0, 1, 1, 0, '0, 1);
        chk("rst_req", {63'd0, bus.IMem_Req}, 64'd0);
        chk("rst_v", {63'd0, IFID_Valid}, 64'd0);

        // Zero-wait fetch from reset
        step(1, 1, 1, 0, '0, 1);
        chk("zw_a0", bus.IMem_Addr, 64'h0);
        step(1, 1, 1, 0, '0, 1);
        chk("zw_a4", bus.IMem_Addr, 64'h4);
        step(1, 1, 1, 0, '0, 1);
        chk("zw_a8", bus.IMem_Addr, 64'h8);
        chk("zw_ifpc", IFID_PC, 64'h4);
        run(2, 1);
        chk("at10", bus.IMem_Addr, 64'h10);

        // Two-cycle stall with a completed fetch
        step(1, 0, 1, 0, '0, 1);
        chk("hold_req", {63'd0, bus.IMem_Req}, 64'd0);
        chk("hold_ifpc", IFID_PC, 64'hC);
        step(1, 1, 0, 0, '0, 1);
        step(1, 1, 1, 0, '0, 0);
        chk("rel_ifpc", IFID_PC, 64'h10);
        chk("rel_addr", bus.IMem_Addr, 64'h14);

        // Redirect during a 3-cycle wait
        step(1, 1, 1, 1, 64'h20, 1);
        step(1, 1, 1, 1, 64'h103, 0);
        step(1, 1, 1, 0, '0, 0);
        step(1, 1, 1, 0, '0, 0);
        chk("pend_addr", bus.IMem_Addr, 64'h20);
        step(1, 1, 1, 0, '0, 1);
        chk("redir_addr", bus.IMem_Addr, 64'h100);
        chk("redir_v", {63'd0, IFID_Valid}, 64'd0);
        run(1, 1);

        // Redirect together with a stall
        step(1, 1, 0, 1, 64'h200, 1);
        chk("brst_v", {63'd0, IFID_Valid}, 64'd0);
        chk("brst_pc", bus.IMem_Addr, 64'h200);

        // PC wrap
        step(1, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        step(1, 1, 1, 0, '0, 1);
        chk("wrap", bus.IMem_Addr, 64'h0);

        // Reset during an outstanding fetch, then a stray Ready
        run(1, 0);
        step(0, 1, 1, 0, '0, 0);
        step(1, 1, 1, 0, '0, 1);
        chk("late_v", {63'd0, IFID_Valid}, 64'd0);
        chk("late_addr", bus.IMem_Addr, RST_PC);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 100) != 0,
                 ($urandom % 100) >= 20,
                 ($urandom % 100) >= 15,
                 ($urandom % 100) < 10,
                 {$urandom, $urandom},
                 ($urandom % 100) < 60);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter ADDR_W, default 64, PC and instruction-address width.
REQ-002 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 Reset_L  input  1  synchronous, active-low reset.
REQ-005 PC_WriteEn  input  1  1 = PC may advance; 0 = load-use stall.
REQ-006 IFID_WriteEn  input  1  1 = IF/ID register may load; 0 = hold.
REQ-007 Branch_Taken  input  1  redirect request from the later stage, one-cycle pulse.
REQ-008 Branch_Target  input  ADDR_W  redirect address, sampled only when Branch_Taken=1.
REQ-009 IMem_Req  output  1  instruction fetch request.
REQ-010 IMem_Addr  output  ADDR_W  fetch address, stable while IMem_Req=1.
REQ-011 IMem_Ready  input  1  fetch complete this cycle; IMem_Data valid.
REQ-012 IMem_Data  input  32  fetched instruction.
REQ-013 IFID_PC  output  ADDR_W  PC of the instruction in IF/ID.
REQ-014 IFID_Instr  output  32  instruction in IF/ID.
REQ-015 IFID_Valid  output  1  1 = IF/ID holds a real instruction; 0 = bubble.

Function
REQ-016 The block SHALL use states S_RESET, S_FETCH and S_HOLD, with one internal hold buffer (PC and instruction) and one redirect-pending flag plus saved target.
REQ-017 S_RESET SHALL last one cycle with IMem_Req=0, then go to S_FETCH with PC=RESET_PC.
REQ-018 In S_FETCH, IMem_Req SHALL be 1 and IMem_Addr SHALL equal PC; at most one request is outstanding.
REQ-019 A stall SHALL be PC_WriteEn=0 or IFID_WriteEn=0.
REQ-020 S_FETCH with IMem_Ready=1, no stall, no pending or current redirect: IF/ID SHALL load {PC, IMem_Data, 1}, PC SHALL become PC+4, state SHALL stay S_FETCH (1 instruction per cycle at zero-wait memory).
REQ-021 S_FETCH with IMem_Ready=1 and stall: the fetched instruction SHALL be captured in the hold buffer, PC SHALL hold, state SHALL go to S_HOLD, and IF/ID SHALL be unchanged.
REQ-022 S_HOLD: IMem_Req SHALL be 0; on the first non-stall cycle, IF/ID SHALL load from the hold buffer with valid=1, PC SHALL become PC+4, and state SHALL go to S_FETCH.
REQ-023 S_FETCH with IMem_Ready=0 and no stall: IF/ID SHALL load a bubble (IFID_Valid=0, IFID_Instr=0).
REQ-024 Branch_Taken=1 SHALL clear IFID_Valid next cycle regardless of IFID_WriteEn; redirect has priority over stall.
REQ-025 Branch_Taken in S_FETCH with IMem_Ready=1, or in S_HOLD: any returned or buffered instruction SHALL be discarded, PC SHALL become Branch_Target, and state SHALL go to S_FETCH.
REQ-026 Branch_Taken in S_FETCH with IMem_Ready=0: IMem_Addr SHALL stay unchanged, the pending flag and target SHALL be saved, and the eventual response SHALL be discarded, followed by a fetch from the saved target.
REQ-027 A second Branch_Taken while the pending flag is set SHALL overwrite the saved target.
REQ-028 Branch_Target bits [1:0] SHALL be forced to 0.
REQ-029 PC+4 SHALL wrap modulo 2^ADDR_W.

Reset
REQ-030 Reset_L=0 at any clock edge SHALL override all other inputs.
REQ-031 Reset SHALL produce: state S_RESET, PC=RESET_PC, IMem_Req=0, IMem_Addr=RESET_PC, IFID_PC=0, IFID_Instr=0, IFID_Valid=0, pending flag=0, hold buffer empty.
REQ-032 Reset during an outstanding fetch SHALL abandon it; a late IMem_Ready SHALL be ignored until S_FETCH is re-entered.

Structure
REQ-033 Shared package if_stage_pkg SHALL hold the state enum, INSTR_W=32 and PC_INC=4.
REQ-034 IF/ID storage SHALL be one sub-module ifid_pipe_reg (write-enable, flush, sync active-low reset).

Verification
REQ-035 Reset release with zero-wait memory -> IMem_Addr 0,4,8 on consecutive cycles; IFID_PC 0,4 with Valid=1 from cycle 3.
REQ-036 Stall for 2 cycles while Ready=1 at PC=0x10 -> S_HOLD, Req=0, IF/ID unchanged; after release IFID_PC=0x10 and next IMem_Addr=0x14.
REQ-037 Branch_Taken with target 0x103 at PC=0x20 and Ready=0 (3-cycle latency) -> IMem_Addr stays 0x20 and the response is dropped; next fetch at 0x100; IFID_Valid=0 meanwhile.
REQ-038 Branch_Taken in the same cycle as a stall -> IFID_Valid=0 next cycle and PC=target.
REQ-039 PC=2^64-4 with ADDR_W=64 -> next IMem_Addr=0.
REQ-040 Reset_L=0 mid-wait, then Ready pulse -> response ignored, outputs at reset values, fetch restarts at RESET_PC.
